updown_counter_mod: RTL and testbench

//  Parametrised successor to the team's free-running 8-bit counter. Adds

---
 rtl/updown_counter_mod.sv | 70 +++++++
 tb/tb_updown_counter_mod.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// Parametrised up/down event counter with enable prescaler, synchronous load,
// programmable modulo and a one-shot mode that halts at the terminal value.
module updown_counter_mod #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 255,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             one_shot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] qout,
    output logic             tc,
    output logic             done
);

    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAXV     = WIDTH'(MAX_VAL);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic          at_term;

    assign tick    = en && (pre_cnt == PRE_LAST);
    // Terminal value depends on the direction in force at the tick.
    assign at_term = up ? (qout == MAXV) : (qout == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            qout    <= '0;
            tc      <= 1'b0;
            done    <= 1'b0;
            pre_cnt <= '0;
            state   <= ST_RUN;
        end else if (load) begin
            qout    <= (load_val > MAXV) ? MAXV : load_val;
            tc      <= 1'b0;
            done    <= 1'b0;
            pre_cnt <= '0;
            state   <= ST_RUN;
        end else begin
            tc <= 1'b0;
            if (en) begin
                pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            end
            if (tick && (state == ST_RUN)) begin
                if (at_term) begin
                    tc <= 1'b1;
                    if (one_shot) begin
                        done  <= 1'b1;
                        state <= ST_HALT;
                    end else begin
                        qout <= up ? '0 : MAXV;
                    end
                end else begin
                    qout <= up ? qout + WIDTH'(1) : qout - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: two instances (PRESCALE 1 and 4, MAX_VAL 9)
// share stimulus and are compared every cycle against a reference model.
module tb_updown_counter_mod;

    localparam int W    = 8;
    localparam int MAXV = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         one_shot = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q1, q4;
    logic         tc1, tc4, done1, done4;

    int checks = 0;
    int errors = 0;
    int tc_cnt;

    typedef struct {
        int q;
        int pre;
        bit tc;
        bit done;
        bit halt;
    } mdl_t;

    mdl_t m1, m4;

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(W), .MAX_VAL(MAXV), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .one_shot(one_shot),
        .load(load), .load_val(load_val), .qout(q1), .tc(tc1), .done(done1)
    );

    updown_counter_mod #(.WIDTH(W), .MAX_VAL(MAXV), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .up(up), .one_shot(one_shot),
        .load(load), .load_val(load_val), .qout(q4), .tc(tc4), .done(done4)
    );

    // Counter behaviour expressed as modulo arithmetic on integers.
    function automatic mdl_t mstep(mdl_t s, int presc, bit r, bit e, bit u,
                                   bit os, bit ld, int lv);
        mdl_t n;
        n = s;
        n.tc = 1'b0;
        if (r) begin
            n.q = 0; n.pre = 0; n.done = 1'b0; n.halt = 1'b0;
        end else if (ld) begin
            n.q = (lv > MAXV) ? MAXV : lv;
            n.pre = 0; n.done = 1'b0; n.halt = 1'b0;
        end else if (e) begin
            n.pre = s.pre + 1;
            if (n.pre == presc) begin
                n.pre = 0;
                if (!s.halt) begin
                    if (s.q == (u ? MAXV : 0)) begin
                        n.tc = 1'b1;
                        if (os) begin
                            n.done = 1'b1;
                            n.halt = 1'b1;
                        end else begin
                            n.q = u ? 0 : MAXV;
                        end
                    end else begin
                        n.q = (s.q + (u ? 1 : MAXV)) % (MAXV + 1);
                    end
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs already set, advance models, then compare both DUTs.
    task automatic cyc();
        @(posedge clk);
        m1 = mstep(m1, 1, reset, en, up, one_shot, load, int'(load_val));
        m4 = mstep(m4, 4, reset, en, up, one_shot, load, int'(load_val));
        #1;
        chk("q1",    32'(q1),    32'(m1.q));
        chk("tc1",   32'(tc1),   32'(m1.tc));
        chk("done1", 32'(done1), 32'(m1.done));
        chk("q4",    32'(q4),    32'(m4.q));
        chk("tc4",   32'(tc4),   32'(m4.tc));
        chk("done4", 32'(done4), 32'(m4.done));
    endtask

    initial begin
        int exp_dn [4];
        m1 = '{q: 0, pre: 0, tc: 1'b0, done: 1'b0, halt: 1'b0};
        m4 = m1;

        // Reset held three cycles, then idle with en low.
        reset = 1'b1;
        repeat (3) cyc();
        chk("reset_q", 32'(q1), 0);
        chk("reset_tc", 32'(tc1), 0);
        chk("reset_done", 32'(done1), 0);
        reset = 1'b0;
        repeat (5) cyc();
        chk("idle_q", 32'(q1), 0);

        // Free-run up wrap: 30 ticks over modulo 10 give three tc pulses.
        en = 1'b1; up = 1'b1; one_shot = 1'b0;
        tc_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            tc_cnt += int'(tc1);
            if (i == 8) chk("up_at_9", 32'(q1), 9);
            if (i == 9) chk("up_wrap_tc", 32'(tc1), 1);
        end
        chk("up_tc_count", 32'(tc_cnt), 3);

        // Down wrap from 3.
        load = 1'b1; load_val = 8'd3; cyc();
        chk("load3", 32'(q1), 3);
        load = 1'b0; up = 1'b0;
        exp_dn = '{2, 1, 0, 9};
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("down_q", 32'(q1), 32'(exp_dn[i]));
            chk("down_tc", 32'(tc1), (i == 3) ? 1 : 0);
        end

        // One-shot up from 7.
        up = 1'b1; one_shot = 1'b1; load = 1'b1; load_val = 8'd7; cyc();
        load = 1'b0;
        cyc(); chk("os_8", 32'(q1), 8);
        cyc(); chk("os_9", 32'(q1), 9); chk("os_9_tc", 32'(tc1), 0);
        cyc(); chk("os_hit_tc", 32'(tc1), 1); chk("os_hit_done", 32'(done1), 1);
        chk("os_hold", 32'(q1), 9);
        repeat (3) cyc();
        chk("os_halt_q", 32'(q1), 9); chk("os_halt_tc", 32'(tc1), 0);
        chk("os_sticky", 32'(done1), 1);
        load = 1'b1; load_val = 8'd2; cyc();
        chk("os_reload_q", 32'(q1), 2); chk("os_reload_done", 32'(done1), 0);
        load = 1'b0; cyc();
        chk("os_resume", 32'(q1), 3);

        // Prescaler: 16 enabled cycles -> 4 steps, then 8 of 16 toggled cycles -> 2 more.
        one_shot = 1'b0; reset = 1'b1; cyc(); reset = 1'b0;
        for (int i = 0; i < 16; i++) cyc();
        chk("pre_16", 32'(q4), 4);
        for (int i = 0; i < 16; i++) begin
            en = ~en;
            cyc();
        end
        chk("pre_toggle", 32'(q4), 6);
        en = 1'b1;

        // Collisions: load beats tick, load clamps, reset mid-count.
        load = 1'b1; load_val = 8'd5; cyc();
        chk("ld_vs_tick", 32'(q1), 5);
        load_val = 8'd200; cyc();
        chk("ld_clamp", 32'(q1), 9);
        load_val = 8'd3; cyc();
        load = 1'b0;
        cyc(); cyc();
        chk("mid_at_5", 32'(q1), 5);
        reset = 1'b1; cyc();
        chk("mid_reset", 32'(q1), 0);
        reset = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom_range(0, 1));
            one_shot = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = 8'($urandom_range(0, 255));
            reset    = ($urandom_range(0, 63) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
